pipe_mux_tree: RTL and testbench
================================

# pipe_mux_tree

Parametrised, pipelined WIDTH-bit N:1 multiplexer built as a radix-4 tree with one register stage per tree level and a valid/ready handshake. It is the next-generation replacement for the combinational 32:1 bit-select mux and serves register-file read ports and forwarding selection where the full tree does not fit in one cycle. Each accepted request (input vector plus select) produces exactly one output beat, in order, after a fixed latency.

## Interface
- WIDTH, 64, bits per input word and per output word.
- SEL_BITS, 5, select width; INPUTS = 2**SEL_BITS.
- LEVELS, derived = ceil(SEL_BITS/2), pipeline depth; not overridable.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_data  in  WIDTH*INPUTS  flat inputs; input j is in_data[j*WIDTH +: WIDTH].
- in_sel  in  SEL_BITS  selected input index.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  equals in_data word in_sel of the matching request.

## Operation
- Stage k (k = 0..LEVELS-1) resolves sel bits [2k+1:2k] with 4:1 muxes. If SEL_BITS is odd, the last stage is 2:1 on the MSB.
- Stage k registers these values:
  - the reduced word array (INPUTS / 4**(k+1) words, or 1 for the final stage);
  - the unconsumed select bits;
  - a valid bit.
- Global stall: stall = out_valid && !out_ready. When stall is high, every stage register, including its valid bit, holds.
- in_ready = !stall. It depends combinationally on out_ready only.
- When not stalled, each stage loads from its predecessor. Stage 0 loads from the inputs, and its valid bit loads in_valid && in_ready.
- Bubbles are not collapsed. An invalid stage still advances when not stalled.
- out_data and out_valid come straight from the last stage register. There is no combinational path from in_data to out_data.
- out_data is don't-care while out_valid = 0. The bench must not check it in that case.
- Ordering is strict FIFO. No request is dropped or duplicated.

## Timing
- Reset (reset_n = 0 at a rising edge):
  - all valid bits clear to 0;
  - out_data resets to 0 and out_valid to 0;
  - in_ready reads 1 in the first cycle after reset (out_valid = 0 there).
- Reset mid-operation: all in-flight requests are discarded. A request presented in a cycle where reset_n = 0 is not accepted.
- Latency: a request accepted at edge t appears with out_valid = 1 after edge t+LEVELS-1, i.e. LEVELS cycles, if no stall occurs. For the defaults (SEL_BITS = 5, LEVELS = 3) this is 3 cycles.
- Throughput: 1 request per cycle while out_ready = 1.
- Stall: out_data and out_valid stay stable until the handshake completes. in_ready = 0 in the same cycle.
- Simultaneous out_ready rising and in_valid: the request is accepted in that same cycle.
- SEL_BITS = 1: LEVELS = 1, a single 2:1 stage. SEL_BITS = 2: LEVELS = 1, a single 4:1 stage.

## Configuration
- PIPE_MUX_TAG_EN:
  - Defined: adds parameter TAG_W (default 4) and ports in_tag (in, TAG_W) and out_tag (out, TAG_W).
  - The tag travels through the pipeline with its request, stalls identically, and resets to 0.
- Undefined: no tag ports or registers exist. Behaviour is otherwise identical.

## Test plan
- Reset and idle (defaults): hold reset_n = 0 for 2 cycles, then release.
  - Required: out_valid = 0, out_data = 0, in_ready = 1.
  - Hold in_valid = 0 for 10 cycles; out_valid stays 0.
- Single request: set in_data word j = 64'hA5A5_0000_0000_0000 | j for all j, and in_sel = 5'd19, with out_ready = 1.
  - Required: exactly one beat, 3 cycles later, with out_data = 64'hA5A5_0000_0000_0013.
- Streaming: apply in_sel = 0..31 on consecutive cycles with out_ready = 1 throughout.
  - Required: 32 consecutive beats, in order, with out_data low bits = 0..31.
  - Required: in_ready remains 1 throughout.
- Backpressure: stream in_sel = 5, 6, 7, 8 and drop out_ready for 4 cycles once the sel = 5 result is valid.
  - Required: out_data holds the sel = 5 result while stalled, and in_ready = 0 during the stall.
  - Required: after release, outputs are 5, 6, 7, 8 with none lost or duplicated.
- Reset mid-flight: accept 2 requests, then assert reset_n = 0 for 1 cycle.
  - Required: no output beat ever appears for those 2 requests.
- PIPE_MUX_TAG_EN defined, SEL_BITS = 4 (LEVELS = 2): send in_tag = 4'h3 with sel = 9, then 4'hC with sel = 2.
  - Required: out_tag = 4'h3 then 4'hC, each paired with the matching data, 2 cycles after its request.

Source files
------------

// File: rtl/pipe_mux_tree.sv
// pipe_mux_tree: pipelined WIDTH-bit (2**SEL_BITS):1 multiplexer built as a radix-4
// tree with one register stage per tree level. Stage k resolves select bits
// [2k+1:2k]; when SEL_BITS is odd the last stage is a 2:1 on the select MSB.
// Optional feature macro: PIPE_MUX_TAG_EN adds a TAG_W-bit tag that rides
// alongside each request through the pipeline.
//
// Handshake: a beat transfers on the rising edge where valid && ready are both
// high. A producer holds valid (and its payload) until that edge. The pipe
// stalls globally when out_valid && !out_ready. in_ready = !stall, so it
// depends combinationally on out_ready only.
module pipe_mux_tree #(
  parameter int WIDTH    = 64,
  parameter int SEL_BITS = 5
`ifdef PIPE_MUX_TAG_EN
  , parameter int TAG_W  = 4
`endif
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH*(2**SEL_BITS)-1:0]   in_data,
  input  logic [SEL_BITS-1:0]              in_sel,
`ifdef PIPE_MUX_TAG_EN
  input  logic [TAG_W-1:0]                 in_tag,
  output logic [TAG_W-1:0]                 out_tag,
`endif
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data
);

  localparam int INPUTS = 2 ** SEL_BITS;
  localparam int LEVELS = (SEL_BITS + 1) / 2;

  logic stall;

  // Global stall: every stage holds while the last stage cannot hand off.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int IN_W  = INPUTS >> (2 * k);
    localparam int RADIX = (2 * k + 2 <= SEL_BITS) ? 4 : 2;
    localparam int SHIFT = (RADIX == 4) ? 2 : 1;
    localparam int OUT_W = IN_W / RADIX;

    logic [IN_W*WIDTH-1:0]  din;
    logic [SEL_BITS-1:0]    sin;
    logic                   vin;
    logic [1:0]             idx;
    logic [OUT_W*WIDTH-1:0] data_d, data_q;
    logic                   valid_d, valid_q;
`ifdef PIPE_MUX_TAG_EN
    logic [TAG_W-1:0]       tin, tag_d, tag_q;
`endif

    if (k == 0) begin : g_src
      assign din = in_data;
      assign sin = in_sel;
      assign vin = in_valid && in_ready;
`ifdef PIPE_MUX_TAG_EN
      assign tin = in_tag;
`endif
    end else begin : g_src
      assign din = g_stage[k-1].data_q;
      assign sin = g_stage[k-1].g_sel.sel_q;
      assign vin = g_stage[k-1].valid_q;
`ifdef PIPE_MUX_TAG_EN
      assign tin = g_stage[k-1].tag_q;
`endif
    end

    // Advance when not stalled: each output slot picks one of RADIX words;
    // bubbles advance too (valid simply follows the predecessor).
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      idx     = 2'(sin & SEL_BITS'(RADIX - 1));
`ifdef PIPE_MUX_TAG_EN
      tag_d   = tag_q;
`endif
      if (!stall) begin
        valid_d = vin;
`ifdef PIPE_MUX_TAG_EN
        tag_d   = tin;
`endif
        for (int w = 0; w < OUT_W; w++) begin
          data_d[w*WIDTH +: WIDTH] = din[(w*RADIX + int'(idx))*WIDTH +: WIDTH];
        end
      end
    end

    // Stage register; reset clears valid and zeroes the payload.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
`ifdef PIPE_MUX_TAG_EN
        tag_q   <= '0;
`endif
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
`ifdef PIPE_MUX_TAG_EN
        tag_q   <= tag_d;
`endif
      end
    end

    // Unconsumed select bits only exist where a later stage still needs them.
    if (k < LEVELS - 1) begin : g_sel
      logic [SEL_BITS-1:0] sel_d, sel_q;

      // Drop the select bits this stage resolved.
      always_comb begin
        sel_d = sel_q;
        if (!stall) begin
          sel_d = sin >> SHIFT;
        end
      end

      // Select register, held on stall.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sel_q <= '0;
        end else begin
          sel_q <= sel_d;
        end
      end
    end
  end

  assign out_valid = g_stage[LEVELS-1].valid_q;
  assign out_data  = g_stage[LEVELS-1].data_q;
`ifdef PIPE_MUX_TAG_EN
  assign out_tag   = g_stage[LEVELS-1].tag_q;
`endif

endmodule

// File: tb/tb_pipe_mux_tree.sv
// tb_pipe_mux_tree: directed bench for pipe_mux_tree (defaults: WIDTH=64, SEL_BITS=5).
// With PIPE_MUX_TAG_EN defined a second instance (SEL_BITS=4) checks tag transport.
module tb_pipe_mux_tree;

  localparam int W = 64;
  localparam int SB = 5;
  localparam int N = 2 ** SB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W*N-1:0] in_data;
  logic [SB-1:0] in_sel = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] word(input int j);
    return 64'hA5A5_0000_0000_0000 | 64'(j);
  endfunction

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit (got running, required finished)");
    $fatal(1);
  end

`ifdef PIPE_MUX_TAG_EN
  logic [3:0]  m_in_tag = 4'h0;
  logic [3:0]  m_out_tag;
  logic        t_in_valid = 1'b0;
  logic        t_in_ready;
  logic [W*16-1:0] t_in_data;
  logic [3:0]  t_in_sel = '0;
  logic [3:0]  t_in_tag = '0;
  logic        t_out_valid;
  logic        t_out_ready = 1'b1;
  logic [W-1:0] t_out_data;
  logic [3:0]  t_out_tag;

  pipe_mux_tree #(.WIDTH(W), .SEL_BITS(4), .TAG_W(4)) u_tag (
    .clk(clk), .reset_n(reset_n),
    .in_valid(t_in_valid), .in_ready(t_in_ready),
    .in_data(t_in_data), .in_sel(t_in_sel),
    .in_tag(t_in_tag), .out_tag(t_out_tag),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data)
  );
`endif

  pipe_mux_tree #(.WIDTH(W), .SEL_BITS(SB)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
`ifdef PIPE_MUX_TAG_EN
    .in_tag(m_in_tag), .out_tag(m_out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    reset_n = 1'b1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", out_data);
    else pass_cnt++;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
`ifdef PIPE_MUX_TAG_EN
    total_cnt++;
    if (m_out_tag !== 4'h0) $display("FAIL reset_out_tag: got %h want 0", m_out_tag);
    else pass_cnt++;
`endif
    for (int i = 0; i < 10; i++) begin
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL idle_out_valid cyc %0d: got %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_sel = 5'd19;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== (i == 2)) $display("FAIL single_valid after edge %0d: got %b want %b", i, out_valid, (i == 2));
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (out_data !== 64'hA5A5_0000_0000_0013) $display("FAIL single_data: got %h want a5a5000000000013", out_data);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      in_valid = (c < 32);
      in_sel = SB'(c);
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) $display("FAIL stream_in_ready cyc %0d: got %b want 1", c, in_ready);
      else pass_cnt++;
      if (c < 32) exp_q.push_back(word(c));
      cycle();
      total_cnt++;
      if (out_valid !== (c >= 2 && c < 34)) $display("FAIL stream_valid cyc %0d: got %b want %b", c, out_valid, (c >= 2 && c < 34));
      else pass_cnt++;
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total_cnt++;
        if (out_data !== e) $display("FAIL stream_data cyc %0d: got %h want %h", c, out_data, e);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL stream_leftover: got %0d pending want 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled_once = 0;
    bit acc;
    bit cons;
    logic [W-1:0] e;
    exp_q.delete();
    out_ready = 1'b1;
    while (got < 4 && cyc < 60) begin
      out_ready = (stall_left == 0);
      in_valid = (sent < 4);
      in_sel = SB'(5 + sent);
      #1;
      if (stall_left > 0) begin
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready stall %0d: got %b want 0", stall_left, in_ready);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL bp_hold_valid stall %0d: got %b want 1", stall_left, out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== word(5)) $display("FAIL bp_hold_data stall %0d: got %h want %h", stall_left, out_data, word(5));
        else pass_cnt++;
        stall_left--;
      end
      acc = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
        total_cnt++;
        if (out_data !== e) $display("FAIL bp_data beat %0d: got %h want %h", got, out_data, e);
        else pass_cnt++;
        got++;
      end
      if (acc) begin
        exp_q.push_back(word(5 + sent));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid === 1'b1 && !stalled_once) begin
        stalled_once = 1;
        stall_left = 4;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total_cnt++;
    if (!stalled_once || got != 4 || sent != 4) $display("FAIL bp_counts: got stalled=%0d beats=%0d sent=%0d want 1/4/4", stalled_once, got, sent);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      cycle();
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL bp_no_dup cyc %0d: got %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_sel = 5'd1;
    cycle();
    in_sel = 5'd2;
    cycle();
    reset_n = 1'b0;
    in_sel = 5'd3;
    cycle();
    reset_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL midreset_valid cyc %0d: got %b want 0", i, out_valid);
      else pass_cnt++;
      cycle();
    end
  endtask

`ifdef PIPE_MUX_TAG_EN
  task automatic test_tag();
    t_out_ready = 1'b1;
    t_in_valid = 1'b1;
    t_in_sel = 4'd9;
    t_in_tag = 4'h3;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 0) begin
        t_in_sel = 4'd2;
        t_in_tag = 4'hC;
      end else begin
        t_in_valid = 1'b0;
      end
      total_cnt++;
      if (t_out_valid !== (i == 1 || i == 2)) $display("FAIL tag_valid edge %0d: got %b want %b", i, t_out_valid, (i == 1 || i == 2));
      else pass_cnt++;
      if (i == 1) begin
        total_cnt++;
        if (t_out_tag !== 4'h3 || t_out_data !== word(9)) $display("FAIL tag_first: got %h/%h want 3/%h", t_out_tag, t_out_data, word(9));
        else pass_cnt++;
      end
      if (i == 2) begin
        total_cnt++;
        if (t_out_tag !== 4'hC || t_out_data !== word(2)) $display("FAIL tag_second: got %h/%h want c/%h", t_out_tag, t_out_data, word(2));
        else pass_cnt++;
      end
    end
  endtask
`endif

  initial begin
    for (int j = 0; j < N; j++) in_data[j*W +: W] = word(j);
`ifdef PIPE_MUX_TAG_EN
    for (int j = 0; j < 16; j++) t_in_data[j*W +: W] = word(j);
`endif
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_midflight();
`ifdef PIPE_MUX_TAG_EN
    test_tag();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
